// File: rtl/cmp_pipe.sv
// -----------------------------------------------------------------------------
// cmp_pipe
//
// Purpose:
//   Single-stage registered comparator with a valid/ready handshake on both
//   sides. Each accepted operand pair is compared according to a RISC-V branch
//   funct3 code. The one-bit result is held in an output register until the
//   consumer takes it. A saturating counter tallies the delivered results that
//   were true and came from a legal mode.
//
// Ports:
//   Clk          in   1      rising-edge clock
//   Rst          in   1      synchronous active-high reset
//   In_valid     in   1      operand pair presented
//   In_ready     out  1      block can accept an operand pair (combinational)
//   Vin_a        in   N      operand A
//   Vin_b        in   N      operand B
//   Mode         in   3      compare mode (funct3: EQ/NE/LT/GE/LTU/GEU)
//   Flush        in   1      drop the held result and refuse input this cycle
//   Out_valid    out  1      result held
//   Out_ready    in   1      consumer takes the result
//   Vout         out  1      compare result
//   Out_illegal  out  1      held result came from an unsupported mode
//   Clr_cnt      in   1      clear the hit counter
//   Hit_cnt      out  CNT_W  saturating count of delivered true results
// -----------------------------------------------------------------------------
module cmp_pipe #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [N-1:0]     Vin_a,
    input  logic [N-1:0]     Vin_b,
    input  logic [2:0]       Mode,
    input  logic             Flush,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Vout,
    output logic             Out_illegal,
    input  logic             Clr_cnt,
    output logic [CNT_W-1:0] Hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic accept;
    logic xfer;
    logic a_eq_b;
    logic a_lt_b_u;
    logic a_lt_b_s;
    logic next_vout;
    logic next_illegal;

    // The stage can take a new pair when it is empty or its current result
    // leaves on this same edge, which gives back-to-back throughput. Flush
    // blocks the input for the cycle it is asserted.
    assign In_ready = (!Out_valid || Out_ready) && !Flush;
    assign accept   = In_valid && In_ready;
    assign xfer     = Out_valid && Out_ready && !Flush;

    // Signed compare uses bit N-1 as the sign over the full operand width.
    assign a_eq_b   = (Vin_a == Vin_b);
    assign a_lt_b_u = (Vin_a < Vin_b);
    assign a_lt_b_s = ($signed(Vin_a) < $signed(Vin_b));

    // Mode decode. The two funct3 codes with no branch meaning (010, 011)
    // produce a false result flagged as illegal.
    always_comb begin
        next_vout    = 1'b0;
        next_illegal = 1'b0;
        case (Mode)
            3'b000:  next_vout = a_eq_b;
            3'b001:  next_vout = !a_eq_b;
            3'b100:  next_vout = a_lt_b_s;
            3'b101:  next_vout = !a_lt_b_s;
            3'b110:  next_vout = a_lt_b_u;
            3'b111:  next_vout = !a_lt_b_u;
            default: next_illegal = 1'b1;
        endcase
    end

    // Output holding register. Reset wins over everything; Flush empties the
    // stage without touching the data bits; otherwise a new acceptance
    // replaces the held result, and a plain transfer just empties the stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Out_valid   <= 1'b0;
            Vout        <= 1'b0;
            Out_illegal <= 1'b0;
        end else if (Flush) begin
            Out_valid <= 1'b0;
        end else if (accept) begin
            Out_valid   <= 1'b1;
            Vout        <= next_vout;
            Out_illegal <= next_illegal;
        end else if (xfer) begin
            Out_valid <= 1'b0;
        end
    end

    // Hit counter: counts transfers of true, legal results and sticks at its
    // maximum. A clear request wins over an increment on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Hit_cnt <= '0;
        end else if (Clr_cnt) begin
            Hit_cnt <= '0;
        end else if (xfer && Vout && !Out_illegal && (Hit_cnt != CNT_MAX)) begin
            Hit_cnt <= Hit_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// -----------------------------------------------------------------------------
// tb_cmp_pipe
//
// Purpose:
//   Self-checking bench for cmp_pipe. Two instances share every input: one
//   with the default 16-bit hit counter and one with a 2-bit counter so that
//   saturation is reachable. The driver pushes the expected result of each
//   accepted pair into a queue; a negedge monitor compares the DUT outputs
//   against the queue head and a saturating counter model.
// -----------------------------------------------------------------------------
module tb_cmp_pipe;

    localparam logic [2:0] M_EQ  = 3'b000;
    localparam logic [2:0] M_NE  = 3'b001;
    localparam logic [2:0] M_BAD = 3'b010;
    localparam logic [2:0] M_LT  = 3'b100;
    localparam logic [2:0] M_LTU = 3'b110;
    localparam logic [2:0] M_GEU = 3'b111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] vin_a;
    logic [31:0] vin_b;
    logic [2:0]  mode;
    logic        flush;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready_a, out_valid_a, vout_a, out_illegal_a;
    logic [15:0] hit_cnt_a;
    logic        in_ready_b, out_valid_b, vout_b, out_illegal_b;
    logic [1:0]  hit_cnt_b;

    int tests_run = 0;
    int tests_failed = 0;
    int xfer_count = 0;
    int model_cnt_a = 0;
    int model_cnt_b = 0;
    bit after_rst = 1'b0;
    bit rand_on = 1'b0;

    // Expected results in acceptance order: bit 1 = illegal, bit 0 = result.
    logic [1:0] exp_q[$];

    cmp_pipe #(.N(32), .CNT_W(16)) dut_a (
        .Clk(clk), .Rst(rst), .In_valid(in_valid), .In_ready(in_ready_a),
        .Vin_a(vin_a), .Vin_b(vin_b), .Mode(mode), .Flush(flush),
        .Out_valid(out_valid_a), .Out_ready(out_ready), .Vout(vout_a),
        .Out_illegal(out_illegal_a), .Clr_cnt(clr_cnt), .Hit_cnt(hit_cnt_a)
    );

    cmp_pipe #(.N(32), .CNT_W(2)) dut_b (
        .Clk(clk), .Rst(rst), .In_valid(in_valid), .In_ready(in_ready_b),
        .Vin_a(vin_a), .Vin_b(vin_b), .Mode(mode), .Flush(flush),
        .Out_valid(out_valid_b), .Out_ready(out_ready), .Vout(vout_b),
        .Out_illegal(out_illegal_b), .Clr_cnt(clr_cnt), .Hit_cnt(hit_cnt_b)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference compare done with 64-bit integer arithmetic: operands are
    // widened once as unsigned and once with the top bit worth -2^31.
    function automatic logic [1:0] refResult(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  m);
        longint ua, ub, sa, sb;
        logic v, ill;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        v = 1'b0;
        ill = 1'b0;
        case (m)
            3'd0:    v = (ua == ub);
            3'd1:    v = (ua != ub);
            3'd4:    v = (sa < sb);
            3'd5:    v = (sa >= sb);
            3'd6:    v = (ua < ub);
            3'd7:    v = (ua >= ub);
            default: ill = 1'b1;
        endcase
        return {ill, v};
    endfunction

    // One comparison; counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where the driver works.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair (called just after a rising edge) and hold it
    // until accepted; the expected result is queued on the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] m, output int waited);
        bit timed_out;
        in_valid = 1'b1;
        vin_a = a;
        vin_b = b;
        mode = m;
        waited = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready_a && !rst) break;
            waited++;
            if (waited >= 50) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 50 cycles");
            tick();
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(refResult(a, b, m));
            #1;
            in_valid = 1'b0;
            vin_a = $urandom;
            vin_b = $urandom;
            mode = 3'($urandom);
        end
    endtask

    // Send a pair with Out_ready high, check the held result against the
    // directed constants, then return one edge after its transfer.
    task automatic sendAndCheck(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] m,
                                input logic exp_v, input logic exp_ill);
        int w;
        applyStimulus(a, b, m, w);
        @(negedge clk);
        checkOutput({name, "_vout"}, {31'd0, vout_a}, {31'd0, exp_v});
        checkOutput({name, "_illegal"}, {31'd0, out_illegal_a}, {31'd0, exp_ill});
        tick();
    endtask

    task automatic clearCount();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Monitor: at every falling edge compare the DUT state with the model,
    // then predict what the coming rising edge does to the model.
    always @(negedge clk) begin
        bit held;
        bit go;
        held = (exp_q.size() != 0);
        checkOutput("out_valid", {31'd0, out_valid_a}, {31'd0, held});
        checkOutput("out_valid_b", {31'd0, out_valid_b}, {31'd0, held});
        checkOutput("in_ready", {31'd0, in_ready_a}, {31'd0, (!held || out_ready) && !flush});
        checkOutput("in_ready_b", {31'd0, in_ready_b}, {31'd0, (!held || out_ready) && !flush});
        checkOutput("hit_cnt", {16'd0, hit_cnt_a}, model_cnt_a);
        checkOutput("hit_cnt_b", {30'd0, hit_cnt_b}, model_cnt_b);
        if (held) begin
            checkOutput("vout", {31'd0, vout_a}, {31'd0, exp_q[0][0]});
            checkOutput("illegal", {31'd0, out_illegal_a}, {31'd0, exp_q[0][1]});
            checkOutput("vout_b", {31'd0, vout_b}, {31'd0, exp_q[0][0]});
        end
        if (after_rst) begin
            checkOutput("rst_vout", {31'd0, vout_a}, 32'd0);
            checkOutput("rst_illegal", {31'd0, out_illegal_a}, 32'd0);
        end
        go = held && out_ready && !flush && !rst;
        if (rst) begin
            exp_q.delete();
            model_cnt_a = 0;
            model_cnt_b = 0;
        end else begin
            if (clr_cnt) begin
                model_cnt_a = 0;
                model_cnt_b = 0;
            end else if (go && exp_q[0] == 2'b01) begin
                if (model_cnt_a < 65535) model_cnt_a++;
                if (model_cnt_b < 3) model_cnt_b++;
            end
            if (go) xfer_count++;
            if (held && (go || flush)) void'(exp_q.pop_front());
        end
        after_rst = rst;
    end

    // Random traffic on the consumer side and the side controls.
    task automatic randomControls();
        while (rand_on) begin
            out_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(15) == 0);
            clr_cnt = ($urandom_range(31) == 0);
            tick();
        end
        out_ready = 1'b1;
        flush = 1'b0;
        clr_cnt = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Main sequence: reset, directed scenarios, then randomized traffic.
    initial begin
        int w;
        int c0;
        logic [31:0] a, b;
        rst = 1'b1;
        in_valid = 1'b0;
        vin_a = '0;
        vin_b = '0;
        mode = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        clr_cnt = 1'b0;
        tick();
        tick();
        checkOutput("reset_out_valid", {31'd0, out_valid_a}, 32'd0);
        checkOutput("reset_hit_cnt", {16'd0, hit_cnt_a}, 32'd0);
        rst = 1'b0;
        tick();

        // EQ on equal operands.
        clearCount();
        sendAndCheck("eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, M_EQ, 1'b1, 1'b0);
        checkOutput("eq_hit_cnt", {16'd0, hit_cnt_a}, 32'd1);

        // Signed versus unsigned view of the same operands.
        clearCount();
        sendAndCheck("lt", 32'hFFFF_FFFF, 32'h0000_0001, M_LT, 1'b1, 1'b0);
        sendAndCheck("ltu", 32'hFFFF_FFFF, 32'h0000_0001, M_LTU, 1'b0, 1'b0);
        sendAndCheck("geu", 32'hFFFF_FFFF, 32'h0000_0001, M_GEU, 1'b1, 1'b0);
        checkOutput("signed_hit_cnt", {16'd0, hit_cnt_a}, 32'd2);

        // Backpressure: result must stay put while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(32'd1, 32'd2, M_NE, w);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_vout", {31'd0, vout_a}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        c0 = xfer_count;
        @(negedge clk);
        checkOutput("bp_release_in_ready", {31'd0, in_ready_a}, 32'd1);
        tick();
        checkOutput("bp_one_transfer", xfer_count - c0, 32'd1);

        // Unsupported mode leaves the counter alone.
        clearCount();
        sendAndCheck("illegal", 32'h1234_5678, 32'h1234_5678, M_BAD, 1'b0, 1'b1);
        tick();
        checkOutput("illegal_hit_cnt", {16'd0, hit_cnt_a}, 32'd0);

        // Flush a held true result while the consumer is ready.
        out_ready = 1'b0;
        applyStimulus(32'd7, 32'd7, M_EQ, w);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_out_valid", {31'd0, out_valid_a}, 32'd0);
        checkOutput("flush_hit_cnt", {16'd0, hit_cnt_a}, 32'd0);

        // Reset mid-stream with a count and a held true result.
        sendAndCheck("pre_rst", 32'd3, 32'd9, M_LTU, 1'b1, 1'b0);
        out_ready = 1'b0;
        applyStimulus(32'd3, 32'd9, M_LTU, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        checkOutput("rst_vout_now", {31'd0, vout_a}, 32'd0);
        checkOutput("rst_hit_cnt", {16'd0, hit_cnt_a}, 32'd0);
        out_ready = 1'b1;

        // Saturation of the 2-bit counter, then clear against an increment.
        repeat (5) sendAndCheck("sat", 32'h55, 32'h55, M_EQ, 1'b1, 1'b0);
        checkOutput("sat_hit_cnt_b", {30'd0, hit_cnt_b}, 32'd3);
        checkOutput("sat_hit_cnt_a", {16'd0, hit_cnt_a}, 32'd5);
        out_ready = 1'b0;
        applyStimulus(32'h66, 32'h66, M_EQ, w);
        out_ready = 1'b1;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checkOutput("clr_hit_cnt_b", {30'd0, hit_cnt_b}, 32'd0);
        checkOutput("clr_hit_cnt_a", {16'd0, hit_cnt_a}, 32'd0);

        // Throughput: eight pairs accepted on eight consecutive edges.
        c0 = xfer_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'(i), 32'd3, M_LT, w);
            checkOutput("tput_stall", w, 32'd0);
        end
        tick();
        checkOutput("tput_transfers", xfer_count - c0, 32'd8);

        // Randomized traffic against the reference model.
        rand_on = 1'b1;
        fork
            randomControls();
            begin
                for (int i = 0; i < 300; i++) begin
                    a = pickOperand();
                    b = ($urandom_range(3) == 0) ? a : pickOperand();
                    applyStimulus(a, b, 3'($urandom_range(7)), w);
                    if ($urandom_range(3) == 0) tick();
                end
                rand_on = 1'b0;
            end
        join
        repeat (4) tick();
        checkOutput("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 The module SHALL have parameter N, default 32, giving the operand width in bits (N >= 2).
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the hit-counter width in bits.
REQ-003 The module SHALL use a single clock and a synchronous, active-high reset, with ports as follows:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- In_valid  in  1  operand pair presented
- In_ready  out  1  block can accept an operand pair
- Vin_a  in  N  operand A
- Vin_b  in  N  operand B
- Mode  in  3  compare mode, RISC-V branch funct3 encoding
- Flush  in  1  discard the held result; block input for this cycle
- Out_valid  out  1  result held
- Out_ready  in  1  consumer takes the result
- Vout  out  1  compare result
- Out_illegal  out  1  held result came from an unsupported Mode
- Clr_cnt  in  1  clear the hit counter
- Hit_cnt  out  CNT_W  saturating count of delivered true results

Function
REQ-004 Mode decode SHALL be:
- 000 EQ: A==B
- 001 NE: A!=B
- 100 LT: signed A<B
- 101 GE: signed A>=B
- 110 LTU: unsigned A<B
- 111 GEU: unsigned A>=B
REQ-005 Mode 010 or 011 SHALL register Vout=0 and Out_illegal=1; all other modes SHALL register Out_illegal=0.
REQ-006 Signed compares SHALL treat bit N-1 as the sign bit over the full N bits, with no truncation or extension.
REQ-007 In_ready SHALL be combinational and equal (!Out_valid || Out_ready) && !Flush.
REQ-008 An input is accepted on a rising edge with In_valid && In_ready. On acceptance, Vout and Out_illegal SHALL load the computed result and Out_valid SHALL be 1 on the next cycle. Latency is 1 cycle.
REQ-009 An output transfer occurs on a rising edge with Out_valid && Out_ready && !Flush. After a transfer with no new acceptance in the same cycle, Out_valid SHALL go to 0.
REQ-010 An acceptance and an output transfer in the same cycle SHALL replace the held result back-to-back, sustaining 1 result per cycle.
REQ-011 While Out_valid=1 and Out_ready=0, Vout and Out_illegal SHALL hold stable, and In_ready SHALL be 0.
REQ-012 Flush=1 SHALL set Out_valid to 0 on the next edge. No acceptance and no transfer SHALL occur in that cycle. Vout and Out_illegal keep their values but are don't-care while Out_valid=0.
REQ-013 Hit_cnt SHALL increment by 1 on each output transfer with Vout=1 and Out_illegal=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-014 Clr_cnt=1 SHALL set Hit_cnt to 0 on the next edge. Clr_cnt SHALL take priority over a simultaneous increment.
REQ-015 Vin_a, Vin_b and Mode SHALL be ignored whenever no acceptance occurs.

Reset
REQ-016 With Rst=1 at a rising edge, the next-state values SHALL be: Out_valid=0, Vout=0, Out_illegal=0, Hit_cnt=0.
REQ-017 While Rst=1, In_ready SHALL evaluate per REQ-007 and therefore be 1 unless Flush=1.
REQ-018 Rst SHALL take priority over Flush, Clr_cnt and all handshakes.
REQ-019 A reset mid-stream SHALL discard any held result without counting it.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- EQ: N=32, A=B=0xDEADBEEF, Out_ready=1 -> Vout=1 one cycle after acceptance, Hit_cnt=1.
- Signed vs unsigned: A=0xFFFFFFFF, B=0x00000001.
  - LT -> Vout=1.
  - LTU -> Vout=0.
  - GEU -> Vout=1.
  - Hit_cnt=2 after all three transfers.
- Backpressure: accept NE with A=1, B=2, and hold Out_ready=0 for 3 cycles -> Vout=1 stable, In_ready=0. Then Out_ready=1 -> one transfer, In_ready=1.
- Illegal mode: Mode=010 with A=B -> Out_illegal=1, Vout=0, Hit_cnt unchanged.
- Flush and reset:
  - Flush with a held true result and Out_ready=1 -> Out_valid=0 next cycle, Hit_cnt unchanged.
  - Rst mid-stream -> all outputs 0.
- Counter, with CNT_W=2:
  - 5 true transfers -> Hit_cnt=3.
  - Clr_cnt together with a true transfer -> Hit_cnt=0.
- Throughput: 8 back-to-back inputs with Out_ready=1 -> 8 results on 8 consecutive cycles in input order.
